// File: rtl/vid_pkg.sv
// Shared video constants, arbiter state encoding and the pixel type.
package vid_pkg;

    localparam int unsigned H_ACTIVE_DEF = 1280;
    localparam int unsigned V_ACTIVE_DEF = 720;
    localparam int unsigned PIX_W        = 24;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BASE  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_e;

endpackage

// File: rtl/vram_scanout_arbiter.sv
// Shares one pixel-memory port between scanout line prefetch (priority)
// and a pixel-drawing requester whose writes slot in between read bursts.
module vram_scanout_arbiter
    import vid_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned BURST    = 16,
    parameter int unsigned MAX_OUT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_req,
    input  logic [11:0]       line_num,
    output logic              lb_we,
    output logic [11:0]       lb_addr,
    output pixel_t            lb_data,
    output logic              fetch_busy,
    output logic              underrun,
    input  logic              draw_valid,
    output logic              draw_ready,
    input  logic [ADDR_W-1:0] draw_addr,
    input  pixel_t            draw_data,
    output logic              draw_oob,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output pixel_t            mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  pixel_t            mem_rdata
);

    localparam int unsigned XW = $clog2(H_ACTIVE + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned BW = $clog2(BURST + 1);
    localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [11:0]       line_q, line_d;
    logic              pend_q, pend_d;
    logic              abort_q, abort_d;
    logic              in_fetch_q, in_fetch_d;
    logic [XW-1:0]     x_issue_q, x_issue_d;
    logic [XW-1:0]     x_recv_q, x_recv_d;
    logic [OW-1:0]     out_q, out_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    pixel_t            wr_data_q, wr_data_d;
    logic              wr_oob_q, wr_oob_d;
    logic              lb_we_q, lb_we_d;
    logic [11:0]       lb_addr_q, lb_addr_d;
    pixel_t            lb_data_q, lb_data_d;

    logic req_ok;
    logic burst_take;
    logic rd_gnt;
    logic wr_gnt;
    logic rv;

    assign req_ok = line_req && (32'(line_num) < V_ACTIVE);
    assign rd_gnt = mem_req && !mem_we && mem_gnt;
    assign wr_gnt = mem_req && mem_we && mem_gnt;
    assign rv     = mem_rvalid && (out_q != '0);

    assign lb_we   = lb_we_q;
    assign lb_addr = lb_addr_q;
    assign lb_data = lb_data_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers: counters, latched request, captured draw, line-buffer port.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            line_q     <= '0;
            pend_q     <= 1'b0;
            abort_q    <= 1'b0;
            in_fetch_q <= 1'b0;
            x_issue_q  <= '0;
            x_recv_q   <= '0;
            out_q      <= '0;
            burst_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_oob_q   <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_addr_q  <= '0;
            lb_data_q  <= '0;
        end else begin
            base_q     <= base_d;
            line_q     <= line_d;
            pend_q     <= pend_d;
            abort_q    <= abort_d;
            in_fetch_q <= in_fetch_d;
            x_issue_q  <= x_issue_d;
            x_recv_q   <= x_recv_d;
            out_q      <= out_d;
            burst_q    <= burst_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_oob_q   <= wr_oob_d;
            lb_we_q    <= lb_we_d;
            lb_addr_q  <= lb_addr_d;
            lb_data_q  <= lb_data_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        line_d     = line_q;
        pend_d     = pend_q;
        abort_d    = abort_q;
        in_fetch_d = in_fetch_q;
        x_issue_d  = x_issue_q;
        x_recv_d   = x_recv_q;
        out_d      = out_q;
        burst_d    = burst_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_oob_d   = wr_oob_q;
        lb_we_d    = 1'b0;
        lb_addr_d  = lb_addr_q;
        lb_data_d  = lb_data_q;

        unique case ({rd_gnt, rv})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase

        if (rd_gnt) begin
            x_issue_d = x_issue_q + 1'b1;
            if (burst_q != BW'(BURST)) burst_d = burst_q + 1'b1;
        end
        if (rv) x_recv_d = x_recv_q + 1'b1;

        // A new line arriving mid-fetch abandons the current one; the
        // in-flight reads still have to be retired before restarting.
        if (underrun) begin
            line_d  = line_num;
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    line_d  = line_num;
                    state_d = ST_BASE;
                end else if (draw_ready) begin
                    wr_addr_d = draw_addr;
                    wr_data_d = draw_data;
                    wr_oob_d  = ({1'b0, draw_addr} >= PIX_TOTAL);
                    state_d   = ST_WRITE;
                end
            end
            ST_BASE: begin
                base_d     = ADDR_W'(line_q) * ADDR_W'(H_ACTIVE);
                x_issue_d  = '0;
                x_recv_d   = '0;
                burst_d    = '0;
                in_fetch_d = 1'b1;
                state_d    = abort_d ? ST_DRAIN : ST_FETCH;
            end
            ST_FETCH: begin
                if (underrun) begin
                    state_d = ST_DRAIN;
                end else if (burst_take) begin
                    wr_addr_d = draw_addr;
                    wr_data_d = draw_data;
                    wr_oob_d  = ({1'b0, draw_addr} >= PIX_TOTAL);
                    burst_d   = '0;
                    state_d   = ST_WRITE;
                end else if (rd_gnt && (x_issue_q == XW'(H_ACTIVE - 1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                if (req_ok && !in_fetch_q) begin
                    line_d = line_num;
                    pend_d = 1'b1;
                end
                if (wr_oob_q || wr_gnt) begin
                    if (abort_d) begin
                        state_d = ST_DRAIN;
                    end else if (in_fetch_q) begin
                        state_d = ST_FETCH;
                    end else if (pend_d) begin
                        pend_d  = 1'b0;
                        state_d = ST_BASE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort_d) begin
                    if (out_q == '0) begin
                        abort_d = 1'b0;
                        state_d = ST_BASE;
                    end
                end else if (x_recv_q == XW'(H_ACTIVE)) begin
                    in_fetch_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reads belonging to an abandoned line never reach the line buffer.
        lb_we_d = rv && !abort_d;
        if (lb_we_d) begin
            lb_addr_d = 12'(x_recv_q);
            lb_data_d = mem_rdata;
        end
    end

    // Outputs decoded from state: memory request, draw handshake, status pulses.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        draw_ready = 1'b0;
        draw_oob   = 1'b0;
        burst_take = 1'b0;
        fetch_busy = (state_q == ST_BASE) || (state_q == ST_FETCH) ||
                     (state_q == ST_DRAIN) || ((state_q == ST_WRITE) && in_fetch_q);
        underrun   = req_ok && fetch_busy;

        case (state_q)
            ST_IDLE: begin
                draw_ready = draw_valid && !req_ok && !rst;
            end
            ST_FETCH: begin
                burst_take = (burst_q == BW'(BURST)) && draw_valid && !req_ok;
                draw_ready = burst_take;
                if (!burst_take && (out_q < OW'(MAX_OUT))) begin
                    mem_req  = 1'b1;
                    mem_addr = base_q + ADDR_W'(x_issue_q);
                end
            end
            ST_WRITE: begin
                if (wr_oob_q) begin
                    draw_oob = 1'b1;
                end else begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr_q;
                    mem_wdata = wr_data_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Bench for vram_scanout_arbiter: H=32, V=8, BURST=8, MAX_OUT=4, memory
// grants every cycle and returns data = address three cycles after grant.
module tb_vram_scanout_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          line_req = 1'b0;
    logic [11:0]   line_num = '0;
    logic          lb_we;
    logic [11:0]   lb_addr;
    logic [23:0]   lb_data;
    logic          fetch_busy;
    logic          underrun;
    logic          draw_valid = 1'b0;
    logic          draw_ready;
    logic [AW-1:0] draw_addr = '0;
    logic [23:0]   draw_data = '0;
    logic          draw_oob;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic          mem_gnt = 1'b1;
    logic          mem_rvalid = 1'b0;
    logic [23:0]   mem_rdata = '0;

    vram_scanout_arbiter #(
        .H_ACTIVE (32),
        .V_ACTIVE (8),
        .ADDR_W   (AW),
        .BURST    (8),
        .MAX_OUT  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line_req   (line_req),
        .line_num   (line_num),
        .lb_we      (lb_we),
        .lb_addr    (lb_addr),
        .lb_data    (lb_data),
        .fetch_busy (fetch_busy),
        .underrun   (underrun),
        .draw_valid (draw_valid),
        .draw_ready (draw_ready),
        .draw_addr  (draw_addr),
        .draw_data  (draw_data),
        .draw_oob   (draw_oob),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: 3-cycle read latency, data = address.
    logic          p1 = 1'b0, p2 = 1'b0;
    logic [AW-1:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        p1         <= mem_req && mem_gnt && !mem_we;
        a1         <= mem_addr;
        p2         <= p1;
        a2         <= a1;
        mem_rvalid <= p2;
        mem_rdata  <= 24'(a2);
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [23:0]   wdata;
    } txn_t;

    typedef struct {
        logic [11:0] addr;
        logic [23:0] data;
    } lbw_t;

    // dmode: 0 no draw, 1 draw raised with line_req, 2 draw raised one cycle later
    typedef struct {
        logic [11:0]   line;
        int            dmode;
        logic [AW-1:0] daddr;
        logic [23:0]   ddata;
        int            exp_base;
        logic          exp_fetch;
    } vec_t;

    txn_t txn_q[$];
    lbw_t lb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hs_cnt   = 0;
    int   ur_cnt   = 0;
    int   oob_cnt  = 0;
    logic skip_rd  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every granted memory request and every line-buffer write.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_gnt) begin
                if (!(skip_rd && (txn_q.size() == 0 || mem_we || mem_addr != txn_q[0].addr))) begin
                    skip_rd = 1'b0;
                    if (txn_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mem_unexpected act=we%0d/%0h exp=none", mem_we, mem_addr);
                    end else begin
                        txn_t e;
                        e = txn_q.pop_front();
                        chk("mem_txn", {mem_we, mem_addr, mem_wdata}, {e.we, e.addr, e.wdata});
                    end
                end
            end
            if (lb_we) begin
                chk("busy_at_lbwe", fetch_busy, 1);
                if (lb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL lb_unexpected act=%0h:%0h exp=none", lb_addr, lb_data);
                end else begin
                    lbw_t l;
                    l = lb_q.pop_front();
                    chk("lb_write", {lb_addr, lb_data}, {l.addr, l.data});
                end
            end
            if (draw_valid && draw_ready) hs_cnt++;
            if (underrun) ur_cnt++;
            if (draw_oob) oob_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input int base, input bit with_wr,
                             input logic [AW-1:0] wa, input logic [23:0] wd);
        for (int i = 0; i < 32; i++) begin
            if (with_wr && i == 8) txn_q.push_back('{1'b1, wa, wd});
            txn_q.push_back('{1'b0, AW'(base + i), 24'h0});
            lb_q.push_back('{12'(i), 24'(base + i)});
        end
    endtask

    // Run until all expectations are consumed and the fetch has ended,
    // dropping draw_valid after each completed handshake.
    task automatic wait_done(input string tag);
        int hs0;
        hs0 = hs_cnt;
        for (int c = 0; c < 400; c++) begin
            step();
            if (hs_cnt != hs0) begin
                draw_valid = 1'b0;
                hs0 = hs_cnt;
            end
            if (txn_q.size() == 0 && lb_q.size() == 0 && !fetch_busy) break;
        end
        chk({tag, "_txn_left"}, txn_q.size(), 0);
        chk({tag, "_lb_left"}, lb_q.size(), 0);
        chk({tag, "_busy_end"}, fetch_busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int hs0, ur0;
        hs0 = hs_cnt;
        ur0 = ur_cnt;
        if (v.exp_fetch) push_line(v.exp_base, v.dmode != 0, v.daddr, v.ddata);
        step();
        line_req = 1'b1;
        line_num = v.line;
        if (v.dmode == 1) begin
            draw_valid = 1'b1;
            draw_addr  = v.daddr;
            draw_data  = v.ddata;
        end
        @(negedge clk);
        if (v.dmode == 1) chk("ready_vs_linereq", draw_ready, 0);
        chk("req_t0", mem_req, 0);
        step();
        line_req = 1'b0;
        if (v.dmode == 2) begin
            draw_valid = 1'b1;
            draw_addr  = v.daddr;
            draw_data  = v.ddata;
        end
        @(negedge clk);
        chk("busy_t1", fetch_busy, v.exp_fetch);
        chk("req_t1", mem_req, 0);
        @(negedge clk);
        chk("req_t2", mem_req, v.exp_fetch);
        wait_done("vec");
        repeat (4) step();
        chk("vec_handshakes", hs_cnt - hs0, (v.dmode != 0) ? 1 : 0);
        chk("vec_underrun", ur_cnt - ur0, 0);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t v0;
        int   ur0, oob0, hs0;

        vecs[0] = '{12'd2, 0, 10'd0, 24'h0,      64,  1'b1};
        vecs[1] = '{12'd2, 2, 10'd5, 24'h123456, 64,  1'b1};
        vecs[2] = '{12'd7, 0, 10'd0, 24'h0,      224, 1'b1};
        vecs[3] = '{12'd8, 0, 10'd0, 24'h0,      0,   1'b0};
        vecs[4] = '{12'd1, 1, 10'd7, 24'hA5A5A5, 32,  1'b1};

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_lb", {lb_we, lb_addr, lb_data}, 0);
        chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_flags", {fetch_busy, underrun, draw_ready, draw_oob}, 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Underrun: line 3 then line 4 while line 3 has reads in flight
        ur0 = ur_cnt;
        txn_q.push_back('{1'b0, AW'(96), 24'h0});
        txn_q.push_back('{1'b0, AW'(97), 24'h0});
        step();
        line_req = 1'b1;
        line_num = 12'd3;
        step();
        line_req = 1'b0;
        repeat (2) step();
        step();
        line_req = 1'b1;
        line_num = 12'd4;
        txn_q.delete();
        lb_q.delete();
        push_line(128, 1'b0, '0, '0);
        skip_rd = 1'b1;
        @(negedge clk);
        chk("underrun_pulse", underrun, 1);
        step();
        line_req = 1'b0;
        wait_done("underrun");
        chk("underrun_count", ur_cnt - ur0, 1);

        // Out-of-range draw, then out-of-range line
        oob0 = oob_cnt;
        ur0  = ur_cnt;
        step();
        draw_valid = 1'b1;
        draw_addr  = 10'd256;
        draw_data  = 24'hDEAD01;
        @(negedge clk);
        chk("oob_ready", draw_ready, 1);
        step();
        draw_valid = 1'b0;
        @(negedge clk);
        chk("oob_pulse", draw_oob, 1);
        chk("oob_no_req", mem_req, 0);
        step();
        @(negedge clk);
        chk("oob_ended", draw_oob, 0);
        step();
        line_req = 1'b1;
        line_num = 12'd8;
        step();
        line_req = 1'b0;
        @(negedge clk);
        chk("bad_line_busy", fetch_busy, 0);
        repeat (4) step();
        chk("oob_count", oob_cnt - oob0, 1);
        chk("bad_line_underrun", ur_cnt - ur0, 0);

        // Draw from IDLE, line_req during its WRITE is latched without underrun
        ur0 = ur_cnt;
        hs0 = hs_cnt;
        txn_q.push_back('{1'b1, AW'(9), 24'h0F0F0F});
        step();
        draw_valid = 1'b1;
        draw_addr  = 10'd9;
        draw_data  = 24'h0F0F0F;
        @(negedge clk);
        chk("idle_ready", draw_ready, 1);
        step();
        draw_valid = 1'b0;
        line_req   = 1'b1;
        line_num   = 12'd6;
        push_line(192, 1'b0, '0, '0);
        @(negedge clk);
        chk("write_req", {mem_req, mem_we}, 2'b11);
        chk("write_no_underrun", underrun, 0);
        step();
        line_req = 1'b0;
        wait_done("pending");
        chk("pending_underrun", ur_cnt - ur0, 0);
        chk("pending_handshakes", hs_cnt - hs0, 1);

        // Reset mid-fetch, then a clean fetch of line 0
        push_line(160, 1'b0, '0, '0);
        step();
        line_req = 1'b1;
        line_num = 12'd5;
        step();
        line_req = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_lb", {lb_we, lb_addr, lb_data}, 0);
        chk("midrst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("midrst_flags", {fetch_busy, underrun, draw_ready, draw_oob}, 0);
        txn_q.delete();
        lb_q.delete();
        repeat (5) step();
        rst = 1'b0;
        step();
        v0 = '{12'd0, 0, 10'd0, 24'h0, 0, 1'b1};
        run_vec(v0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
